// File: rtl/pipeline_fifo.sv
// pipeline_fifo: Depth-entry elastic buffer, 1-cycle write->read latency, wr_ready_o depends on occupancy only.
// Defining PIPE_FIFO_BYPASS_EN adds a 0-cycle combinational bypass when the buffer is empty.
module pipeline_fifo #(
  parameter int Width = 32,
  parameter int Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         wr_valid_i,
  input  logic [Width-1:0]             wr_data_i,
  output logic                         wr_ready_o,
  input  logic                         rd_ready_i,
  output logic [Width-1:0]             rd_data_o,
  output logic                         rd_valid_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);
  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             stored_vld;
  logic             push;
  logic             pop;
  logic             store;

  // Depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign stored_vld = (count != '0);
  assign wr_ready_o = (count != FullCnt);
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = stored_vld & rd_ready_i;
  assign count_o    = count;

`ifdef PIPE_FIFO_BYPASS_EN
  logic bypass;
  assign bypass     = ~stored_vld & wr_valid_i & ~flush_i;
  // A bypassed item consumed in the same cycle never occupies storage.
  assign store      = push & ~(bypass & rd_ready_i);
  assign rd_valid_o = ~flush_i & (stored_vld | bypass);
  assign rd_data_o  = bypass ? wr_data_i : mem[rd_ptr];
`else
  assign store      = push;
  assign rd_valid_o = stored_vld;
  assign rd_data_o  = mem[rd_ptr];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      // Storage is left as-is; only occupancy and pointers are discarded.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= wr_data_i;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_fifo.sv
// Scoreboard bench for pipeline_fifo at Depth=4; expectations track the PIPE_FIFO_BYPASS_EN build.
module tb_pipeline_fifo;
  localparam int W = 32;
  localparam int D = 4;
`ifdef PIPE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_ready;
  logic         rd_ready = 1'b0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic [2:0]   count;

  int nt = 0;
  int nf = 0;
  logic [W-1:0] exp_q[$];

  pipeline_fifo #(.Width(W), .Depth(D)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic wv, input logic [W-1:0] wd, input logic rr,
                       input logic fl, input logic rs);
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl; rst = rs;
  endtask

  // Advance one clock, updating the scoreboard from the driven inputs.
  task automatic tick();
    int sz;
    bit take, acc, pp;
    sz = exp_q.size();
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      take = BYP && sz == 0 && wr_valid && rd_ready;
      pp   = rd_ready && sz > 0;
      acc  = wr_valid && sz < D && !take;
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(wr_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0, 1); tick(); tick();
    drive(1, 32'hDEAD_0001, 0, 0, 0); tick();
    drive(1, 32'hDEAD_0002, 1, 0, 0); tick();
    drive(1, 32'hDEAD_0003, 1, 0, 1); tick(); tick();
    drive(0, '0, 0, 0, 0); #1;
    nt++; if (rd_valid !== 1'b0) begin nf++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    nt++; if (wr_ready !== 1'b1) begin nf++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    nt++; if (count !== 3'd0) begin nf++; $display("FAIL reset_count got=%0d exp=0", count); end
    nt++; if (rd_data !== 32'h0) begin nf++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      drive(1, 32'hA0 + i, 0, 0, 0); #1;
      nt++; if (wr_ready !== 1'b1) begin nf++; $display("FAIL fill_wr_ready[%0d] got=%b exp=1", i, wr_ready); end
      tick();
    end
    drive(1, 32'hA4, 0, 0, 0); #1;
    nt++; if (count !== 3'd4) begin nf++; $display("FAIL fill_count got=%0d exp=4", count); end
    nt++; if (wr_ready !== 1'b0) begin nf++; $display("FAIL full_wr_ready got=%b exp=0", wr_ready); end
    tick();
    nt++; if (count !== 3'd4) begin nf++; $display("FAIL held_count got=%0d exp=4", count); end
    nt++; if (rd_data !== 32'hA0) begin nf++; $display("FAIL held_rd_data got=%h exp=a0", rd_data); end
  endtask

  task automatic test_full_pop();
    drive(1, 32'hA4, 1, 0, 0); #1;
    nt++; if (wr_ready !== 1'b0) begin nf++; $display("FAIL fullpop_wr_ready got=%b exp=0", wr_ready); end
    nt++; if (rd_data !== exp_q[0]) begin nf++; $display("FAIL fullpop_rd_data got=%h exp=%h", rd_data, exp_q[0]); end
    tick();
    drive(0, '0, 0, 0, 0); #1;
    nt++; if (count !== 3'd3) begin nf++; $display("FAIL fullpop_count got=%0d exp=3", count); end
    nt++; if (rd_data !== 32'hA1) begin nf++; $display("FAIL fullpop_next got=%h exp=a1", rd_data); end
    while (exp_q.size() > 0) begin
      drive(0, '0, 1, 0, 0); #1;
      nt++; if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
        nf++; $display("FAIL drain_data got=%b/%h exp=1/%h", rd_valid, rd_data, exp_q[0]);
      end
      tick();
    end
    nt++; if (rd_valid !== 1'b0 || count !== 3'd0) begin
      nf++; $display("FAIL drain_empty got=%b/%0d exp=0/0", rd_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    logic [W-1:0] e;
    logic ev;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1, 32'h1000 + i, 1, 0, 0); #1;
      ev = (exp_q.size() > 0) || BYP;
      e  = (exp_q.size() > 0) ? exp_q[0] : wr_data;
      nt++; if (rd_valid !== ev) begin nf++; $display("FAIL stream_vld[%0d] got=%b exp=%b", i, rd_valid, ev); end
      if (ev) begin
        nt++; if (rd_data !== e) begin nf++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, rd_data, e); end
      end
      if (rd_valid === 1'b1) seen++;
      tick();
      nt++; if (count !== (BYP ? 3'd0 : 3'd1)) begin
        nf++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", i, count, BYP ? 0 : 1);
      end
    end
    nt++; if (seen != (BYP ? 100 : 99)) begin nf++; $display("FAIL stream_throughput got=%0d exp=%0d", seen, BYP ? 100 : 99); end
    while (exp_q.size() > 0) begin
      drive(0, '0, 1, 0, 0); #1;
      nt++; if (rd_data !== exp_q[0]) begin nf++; $display("FAIL stream_tail got=%h exp=%h", rd_data, exp_q[0]); end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h30 + i, 0, 0, 0); tick();
    end
    nt++; if (count !== 3'd3) begin nf++; $display("FAIL preflush_count got=%0d exp=3", count); end
    drive(1, 32'h55, 0, 1, 0); #1;
    if (BYP) begin
      nt++; if (rd_valid !== 1'b0) begin nf++; $display("FAIL flush_cycle_vld got=%b exp=0", rd_valid); end
    end
    tick();
    drive(0, '0, 1, 0, 0); #1;
    nt++; if (count !== 3'd0) begin nf++; $display("FAIL flush_count got=%0d exp=0", count); end
    nt++; if (wr_ready !== 1'b1) begin nf++; $display("FAIL flush_wr_ready got=%b exp=1", wr_ready); end
    for (int i = 0; i < 3; i++) begin
      nt++; if (rd_valid !== 1'b0 || rd_data === 32'h55) begin
        nf++; $display("FAIL flush_idle[%0d] got=%b/%h exp=0/not55", i, rd_valid, rd_data);
      end
      tick(); #1;
    end
    drive(1, 32'h66, 0, 0, 0); tick();
    drive(0, '0, 0, 0, 0); #1;
    nt++; if (rd_valid !== 1'b1 || rd_data !== exp_q[0] || count !== 3'd1) begin
      nf++; $display("FAIL postflush_write got=%b/%h/%0d exp=1/%h/1", rd_valid, rd_data, count, exp_q[0]);
    end
    drive(0, '0, 1, 0, 0); tick();
  endtask

  task automatic test_bypass();
    drive(1, 32'h77, 1, 0, 0); #1;
    nt++; if (rd_valid !== BYP) begin nf++; $display("FAIL bypass_same_vld got=%b exp=%b", rd_valid, BYP); end
    if (BYP) begin
      nt++; if (rd_data !== 32'h77) begin nf++; $display("FAIL bypass_same_data got=%h exp=77", rd_data); end
    end
    tick();
    drive(0, '0, 0, 0, 0); #1;
    if (BYP) begin
      nt++; if (count !== 3'd0 || rd_valid !== 1'b0) begin
        nf++; $display("FAIL bypass_after got=%0d/%b exp=0/0", count, rd_valid);
      end
    end else begin
      nt++; if (rd_valid !== 1'b1 || rd_data !== 32'h77 || count !== 3'd1) begin
        nf++; $display("FAIL bypass_next got=%b/%h/%0d exp=1/77/1", rd_valid, rd_data, count);
      end
      drive(0, '0, 1, 0, 0); tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_flush();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
